// File: rtl/stack_pkg.sv
// Shared types and sizing helpers for the LIFO stack datapath.
package stack_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } stackState_t;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int countWidth(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/stack_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one combinational read port.
module stack_mem
  import stack_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Contents are never cleared; only occupied entries are ever read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/lifo_stack.sv
// LIFO stack with registered pop port, occupancy tracking and sticky error flags.
module lifo_stack
  import stack_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                         Clk,
  input  logic                         Clr_n,
  input  logic                         Push,
  input  logic [WIDTH-1:0]             Din,
  input  logic                         Pop,
  output logic [WIDTH-1:0]             Dout,
  output logic                         Dout_valid,
  output logic                         Full,
  output logic                         Empty,
  output logic [countWidth(DEPTH)-1:0] Count,
  output logic                         Overflow,
  output logic                         Underflow
);

  localparam int CW = countWidth(DEPTH);
  localparam int AW = $clog2(DEPTH);

  stackState_t      state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             doutValid_q, doutValid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             wrEn;
  logic [AW-1:0]    wrAddr;
  logic [AW-1:0]    topAddr;
  logic [WIDTH-1:0] rdData;
  logic             isEmpty;
  logic             isFull;

  assign isEmpty = (state_q == EMPTY);
  assign isFull  = (state_q == FULL);
  // Top-of-stack index is only formed when something is stored.
  assign topAddr = (count_q != '0) ? AW'(count_q - CW'(1)) : '0;

  stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (Clk),
    .wr_en   (wrEn),
    .wr_addr (wrAddr),
    .wr_data (Din),
    .rd_addr (topAddr),
    .rd_data (rdData)
  );

  always_ff @(posedge Clk) begin
    if (!Clr_n) begin
      state_q     <= EMPTY;
      count_q     <= '0;
      dout_q      <= '0;
      doutValid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      dout_q      <= dout_d;
      doutValid_q <= doutValid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_comb begin
    count_d     = count_q;
    dout_d      = dout_q;
    doutValid_d = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    wrEn        = 1'b0;
    wrAddr      = AW'(count_q);
    if (Push && Pop) begin
      if (isEmpty) begin
        wrEn        = 1'b1;
        count_d     = CW'(1);
        underflow_d = 1'b1;
      end else begin
        // Replace-top: old top leaves on Dout while Din overwrites it.
        dout_d      = rdData;
        doutValid_d = 1'b1;
        wrEn        = 1'b1;
        wrAddr      = topAddr;
      end
    end else if (Push) begin
      if (isFull) begin
        overflow_d = 1'b1;
      end else begin
        wrEn    = 1'b1;
        count_d = count_q + CW'(1);
      end
    end else if (Pop) begin
      if (isEmpty) begin
        underflow_d = 1'b1;
      end else begin
        dout_d      = rdData;
        doutValid_d = 1'b1;
        count_d     = count_q - CW'(1);
      end
    end
    wrEn = wrEn & Clr_n;

    if (count_d == '0) begin
      state_d = EMPTY;
    end else if (count_d == CW'(DEPTH)) begin
      state_d = FULL;
    end else begin
      state_d = PARTIAL;
    end
  end

  always_comb begin
    Empty      = (state_q == EMPTY);
    Full       = (state_q == FULL);
    Count      = count_q;
    Dout       = dout_q;
    Dout_valid = doutValid_q;
    Overflow   = overflow_q;
    Underflow  = underflow_q;
  end

endmodule

// File: tb/tb_lifo_stack.sv
// Directed self-checking bench for lifo_stack (WIDTH=8, DEPTH=8).
module tb_lifo_stack;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             Clk;
  logic             Clr_n;
  logic             Push;
  logic [WIDTH-1:0] Din;
  logic             Pop;
  logic [WIDTH-1:0] Dout;
  logic             Dout_valid;
  logic             Full;
  logic             Empty;
  logic [CW-1:0]    Count;
  logic             Overflow;
  logic             Underflow;

  int checks   = 0;
  int failures = 0;

  lifo_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .Clk        (Clk),
    .Clr_n      (Clr_n),
    .Push       (Push),
    .Din        (Din),
    .Pop        (Pop),
    .Dout       (Dout),
    .Dout_valid (Dout_valid),
    .Full       (Full),
    .Empty      (Empty),
    .Count      (Count),
    .Overflow   (Overflow),
    .Underflow  (Underflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
  task automatic applyStimulus(input logic clrN, input logic push, input logic pop,
                               input logic [WIDTH-1:0] din);
    Clr_n = clrN;
    Push  = push;
    Pop   = pop;
    Din   = din;
    @(posedge Clk);
    #1;
    Clr_n = 1'b1;
    Push  = 1'b0;
    Pop   = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    Clr_n = 1'b0;
    Push  = 1'b0;
    Pop   = 1'b0;
    Din   = '0;

    // Reset state
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("rst_count", 32'(Count), 32'd0);
    checkOutput("rst_empty", 32'(Empty), 32'd1);
    checkOutput("rst_full", 32'(Full), 32'd0);
    checkOutput("rst_dout", 32'(Dout), 32'h00);
    checkOutput("rst_valid", 32'(Dout_valid), 32'd0);
    checkOutput("rst_ovf", 32'(Overflow), 32'd0);
    checkOutput("rst_unf", 32'(Underflow), 32'd0);

    // Pop while empty
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
    checkOutput("epop_dout", 32'(Dout), 32'h00);
    checkOutput("epop_valid", 32'(Dout_valid), 32'd0);
    checkOutput("epop_unf", 32'(Underflow), 32'd1);
    checkOutput("epop_empty", 32'(Empty), 32'd1);
    checkOutput("epop_count", 32'(Count), 32'd0);

    // Push three, pop three in reverse
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h11);
    checkOutput("p1_count", 32'(Count), 32'd1);
    checkOutput("p1_empty", 32'(Empty), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h22);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h33);
    checkOutput("p3_count", 32'(Count), 32'd3);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
    checkOutput("pop1_dout", 32'(Dout), 32'h33);
    checkOutput("pop1_valid", 32'(Dout_valid), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
    checkOutput("pop2_dout", 32'(Dout), 32'h22);
    checkOutput("pop2_valid", 32'(Dout_valid), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
    checkOutput("pop3_dout", 32'(Dout), 32'h11);
    checkOutput("pop3_valid", 32'(Dout_valid), 32'd1);
    checkOutput("pop3_empty", 32'(Empty), 32'd1);
    checkOutput("pop3_count", 32'(Count), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("idle_dout", 32'(Dout), 32'h11);
    checkOutput("idle_valid", 32'(Dout_valid), 32'd0);
    checkOutput("idle_unf_sticky", 32'(Underflow), 32'd1);

    // Fill to full, overflow, pop top
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("rst2_unf", 32'(Underflow), 32'd0);
    for (int i = 1; i <= DEPTH; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 8'(i));
    end
    checkOutput("fill_full", 32'(Full), 32'd1);
    checkOutput("fill_count", 32'(Count), 32'd8);
    checkOutput("fill_ovf", 32'(Overflow), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h09);
    checkOutput("ovf_flag", 32'(Overflow), 32'd1);
    checkOutput("ovf_count", 32'(Count), 32'd8);
    checkOutput("ovf_full", 32'(Full), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
    checkOutput("fpop_dout", 32'(Dout), 32'h08);
    checkOutput("fpop_count", 32'(Count), 32'd7);
    checkOutput("fpop_full", 32'(Full), 32'd0);

    // Replace-top while full
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h08);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'hEE);
    checkOutput("frep_dout", 32'(Dout), 32'h08);
    checkOutput("frep_valid", 32'(Dout_valid), 32'd1);
    checkOutput("frep_count", 32'(Count), 32'd8);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
    checkOutput("frep_pop", 32'(Dout), 32'hEE);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
    checkOutput("frep_pop2", 32'(Dout), 32'h07);

    // Replace-top with Count=3
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h11);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h22);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h33);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'hAA);
    checkOutput("rep_dout", 32'(Dout), 32'h33);
    checkOutput("rep_count", 32'(Count), 32'd3);
    checkOutput("rep_ovf", 32'(Overflow), 32'd0);
    checkOutput("rep_unf", 32'(Underflow), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
    checkOutput("rep_pop", 32'(Dout), 32'hAA);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
    checkOutput("rep_pop2", 32'(Dout), 32'h22);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
    checkOutput("rep_pop3", 32'(Dout), 32'h11);
    checkOutput("rep_empty", 32'(Empty), 32'd1);

    // Push+Pop while empty
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h5A);
    checkOutput("epp_count", 32'(Count), 32'd1);
    checkOutput("epp_unf", 32'(Underflow), 32'd1);
    checkOutput("epp_valid", 32'(Dout_valid), 32'd0);
    checkOutput("epp_dout_hold", 32'(Dout), 32'h11);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
    checkOutput("epp_pop", 32'(Dout), 32'h5A);
    checkOutput("epp_pop_valid", 32'(Dout_valid), 32'd1);
    checkOutput("epp_pop_empty", 32'(Empty), 32'd1);

    // Reset mid-operation with Count=5 and Overflow set
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < DEPTH + 1; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 8'(8'h40 + i));
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
    end
    checkOutput("pre_count", 32'(Count), 32'd5);
    checkOutput("pre_ovf", 32'(Overflow), 32'd1);
    checkOutput("pre_dout", 32'(Dout), 32'h45);
    checkOutput("pre_valid", 32'(Dout_valid), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hC3);
    checkOutput("mrst_count", 32'(Count), 32'd0);
    checkOutput("mrst_ovf", 32'(Overflow), 32'd0);
    checkOutput("mrst_empty", 32'(Empty), 32'd1);
    checkOutput("mrst_valid", 32'(Dout_valid), 32'd0);
    checkOutput("mrst_dout", 32'(Dout), 32'h00);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
    checkOutput("mrst_pop_unf", 32'(Underflow), 32'd1);
    checkOutput("mrst_pop_valid", 32'(Dout_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
